// File: rtl/natural_exp.sv
// e^x for signed Q4.12 input, unsigned Q16.16 output.
// x*log2(e) is split into integer shift n and fraction f; 2^f comes from an interpolated LUT.
module natural_exp #(
  parameter int unsigned LOG2E_Q16    = 94548,
  parameter int unsigned LUT_IDX_BITS = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] in_x,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int IB = LUT_IDX_BITS;
  localparam int RB = 12 - IB;

  typedef enum logic [2:0] {
    IDLE, SCALE, SPLIT, INTERP, SHIFT, DONE
  } state_t;

  state_t             r_state;
  logic signed [15:0] r_x;
  logic signed [17:0] r_t;
  logic signed [5:0]  r_n;
  logic [RB-1:0]      r_r;
  logic [16:0]        r_la;
  logic [16:0]        r_lb;
  logic [16:0]        r_y;
  logic [31:0]        r_out;
  logic               r_valid;

  logic signed [33:0] w_prod;
  logic [IB-1:0]      w_i;
  logic [16:0]        w_la;
  logic [16:0]        w_lb;
  logic [16:0]        w_diff;
  logic [RB+16:0]     w_mul;
  logic [16:0]        w_y;
  logic [31:0]        w_ext;
  logic [5:0]         w_rsh;

  // 2^(k/16) in Q1.16, rounded to nearest
  function automatic logic [16:0] lut(input int k);
    logic [16:0] v;
    unique case (k)
      0:       v = 17'd65536;
      1:       v = 17'd68438;
      2:       v = 17'd71468;
      3:       v = 17'd74632;
      4:       v = 17'd77936;
      5:       v = 17'd81386;
      6:       v = 17'd84990;
      7:       v = 17'd88752;
      8:       v = 17'd92682;
      9:       v = 17'd96785;
      10:      v = 17'd101070;
      11:      v = 17'd105545;
      12:      v = 17'd110218;
      13:      v = 17'd115098;
      14:      v = 17'd120194;
      15:      v = 17'd125515;
      16:      v = 17'd131072;
      default: v = 17'd0;
    endcase
    return v;
  endfunction

  assign w_prod = r_x * $signed({1'b0, 17'(LOG2E_Q16)});
  assign w_i    = r_t[11 -: IB];
  assign w_la   = lut(int'(w_i));
  assign w_lb   = lut(int'(w_i) + 1);
  assign w_diff = r_lb - r_la;
  assign w_mul  = w_diff * r_r;
  assign w_y    = r_la + 17'(w_mul >> RB);
  assign w_ext  = {15'd0, r_y};
  assign w_rsh  = 6'(-r_n);

  assign in_ready  = (r_state == IDLE);
  assign out_data  = r_out;
  assign out_valid = r_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_x     <= '0;
      r_t     <= '0;
      r_n     <= '0;
      r_r     <= '0;
      r_la    <= '0;
      r_lb    <= '0;
      r_y     <= '0;
      r_out   <= '0;
      r_valid <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_x     <= in_x;
            r_state <= SCALE;
          end
        end
        SCALE: begin
          // floor of x*log2(e), Q.12
          r_t     <= 18'(w_prod >>> 16);
          r_state <= SPLIT;
        end
        SPLIT: begin
          r_n     <= r_t[17:12];
          r_r     <= r_t[RB-1:0];
          r_la    <= w_la;
          r_lb    <= w_lb;
          r_state <= INTERP;
        end
        INTERP: begin
          r_y     <= w_y;
          r_state <= SHIFT;
        end
        SHIFT: begin
          if (r_n[5]) r_out <= w_ext >> w_rsh;
          else        r_out <= w_ext << r_n;
          r_valid <= 1'b1;
          r_state <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            r_valid <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_natural_exp.sv
// Directed + strided-sweep bench for natural_exp.
// Expected results are queued at accept time and compared at the output handshake.
module tb_natural_exp;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] in_x = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;

  int n_chk = 0;
  int n_fail = 0;
  longint lut_m[17];
  logic [31:0] sb_q[$];
  logic [31:0] d;

  always #5 clk = ~clk;

  natural_exp dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_x     (in_x),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  function automatic logic [31:0] model(input logic [15:0] x);
    longint t, n, f, i, r, y, res;
    t = (longint'($signed(x)) * 64'sd94548) >>> 16;
    n = t >>> 12;
    f = t & 64'hFFF;
    i = f >> 8;
    r = f & 64'hFF;
    y = lut_m[int'(i)] +
        (((lut_m[int'(i)+1] - lut_m[int'(i)]) * r) >> 8);
    res = (n >= 0) ? (y << n) : (y >> (-n));
    return 32'(res);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_tol(input logic [15:0] x, input logic [31:0] obs);
    real ideal, err;
    ideal = $exp(real'($signed(x)) / 4096.0) * 65536.0;
    err = real'(obs) - ideal;
    if (err < 0.0) err = -err;
    n_chk++;
    assert (err <= 0.001 * ideal + 1.0) else begin
      n_fail++;
      $error("FAIL tol x=%h: got %0d want %f", x, obs, ideal);
    end
  endtask

  task automatic send(input logic [15:0] x);
    int cnt = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    chk("send_ready", 32'(in_ready), 32'd1);
    in_x = x;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    sb_q.push_back(model(x));
  endtask

  task automatic wait_valid();
    int cnt = 0;
    while (out_valid !== 1'b1 && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    chk("out_valid_wait", 32'(out_valid), 32'd1);
  endtask

  task automatic recv(input logic [15:0] x, output logic [31:0] dout);
    logic [31:0] e;
    @(negedge clk);
    wait_valid();
    dout = out_data;
    chk("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
    e = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hDEAD_BEEF;
    chk("data", out_data, e);
    chk_tol(x, out_data);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("valid_drop", 32'(out_valid), 32'd0);
    chk("ready_back", 32'(in_ready), 32'd1);
  endtask

  initial begin
    for (int k = 0; k < 17; k++)
      lut_m[k] = longint'($floor(65536.0 * $pow(2.0, real'(k) / 16.0) + 0.5));

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    @(negedge clk) reset_n = 1'b1;

    // x = 0, latency exactly 4 edges
    send(16'h0000);
    repeat (3) @(posedge clk);
    #1 chk("lat_e3", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1 chk("lat_e4", 32'(out_valid), 32'd1);
    recv(16'h0000, d);
    chk("x0_const", d, 32'h0001_0000);

    // x = 1.0 and -1.0
    send(16'h1000);
    recv(16'h1000, d);
    send(16'hF000);
    recv(16'hF000, d);
    chk("xm1_const", d, 32'd24108);

    // range ends
    send(16'h7FFF);
    recv(16'h7FFF, d);
    send(16'h8000);
    recv(16'h8000, d);
    n_chk++;
    assert (d >= 32'd21 && d <= 32'd23) else begin
      n_fail++;
      $error("FAIL xm8_range: got %0d want 21..23", d);
    end

    // backpressure with ignored input pulses
    send(16'h0800);
    @(negedge clk);
    wait_valid();
    for (int c = 0; c < 10; c++) begin
      chk("bp_data", out_data, sb_q[0]);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      in_x = 16'($urandom);
      in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    recv(16'h0800, d);
    send(16'hE800);
    recv(16'hE800, d);

    // reset during INTERP discards the sample
    send(16'h1000);
    @(posedge clk);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_data", out_data, 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    sb_q.delete();
    @(negedge clk) reset_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("post_rst_no_out", 32'(out_valid), 32'd0);
    send(16'h0000);
    recv(16'h0000, d);
    chk("post_rst_x0", d, 32'h0001_0000);

    // strided sweep over the input range
    for (int k = 0; k < 65536; k += 97) begin
      send(16'(k));
      recv(16'(k), d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
